ram_sp_clr: RTL and testbench

Parametrised single-port synchronous RAM with registered read, per-byte write enables, a selectable read-during-write mode and a built-in clear sequencer. The clear sequencer zeroes every word after reset or on request; it replaces simulation-only `initial` initialisation. It is the general-purpose scratch/buffer memory for datapath blocks. It infers one write port and one read port clocked by `clk`, and maps to block RAM where the target provides it.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clr_seq.sv | 53 +++++
 rtl/ram_sp_clr.sv | 123 ++++++++++++
 tb/tb_ram_sp_clr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port clearable RAM: read-during-write
// mode encodings and the clear sequencer state type.
package ram_pkg;

    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_READ_FIRST  = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every word address once after reset or on request,
// flagging the array as busy while it does so.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_adr
);

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    clr_state_t    state;
    logic [AW-1:0] cnt;

    // Clear FSM and address counter; the counter wraps to zero on the last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= {AW{1'b0}};
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= {AW{1'b0}};
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = (state == CLEAR);
    assign clr_adr = cnt;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read, per-byte write enables,
// selectable read-during-write behaviour and a self-clearing sequencer.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DW       = 64,
    parameter int RDW_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            sel,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   adr,
    input  logic [DW-1:0]   dat_i,
    output logic [DW-1:0]   dat_o,
    output logic            rvalid,
    output logic            busy
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    if (RDW_MODE > RDW_READ_FIRST) begin : g_bad_rdw_mode
        $error("ram_sp_clr: RDW_MODE must be 0, 1 or 2");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("ram_sp_clr: DW must be a multiple of 8");
    end

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_adr;

    logic          user_acc;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] merged;

    ram_clr_seq #(
        .AW(AW)
    ) u_clr_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .busy   (busy),
        .clr_we (clr_we),
        .clr_adr(clr_adr)
    );

    // Write-port mux: the clear sequencer owns the array while busy; a clr
    // request drops any access presented in the same cycle.
    always_comb begin
        user_acc = sel && !busy && !clr;
        rd_word  = mem[adr];
        merged   = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = dat_i[8*i +: 8];
            end else begin
                merged[8*i +: 8] = rd_word[8*i +: 8];
            end
        end
        if (clr_we) begin
            wr_en  = 1'b1;
            wr_adr = clr_adr;
            wr_dat = {DW{1'b0}};
            wr_be  = {NB{1'b1}};
        end else begin
            wr_en  = user_acc && we;
            wr_adr = adr;
            wr_dat = dat_i;
            wr_be  = be;
        end
    end

    // Array write port with per-byte lane enables.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_adr][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    // Registered read data and strobe, shaped by the read-during-write mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dat_o  <= {DW{1'b0}};
            rvalid <= 1'b0;
        end else if (user_acc) begin
            if (!we) begin
                dat_o  <= rd_word;
                rvalid <= 1'b1;
            end else begin
                case (RDW_MODE)
                    RDW_WRITE_FIRST: begin
                        dat_o  <= merged;
                        rvalid <= 1'b1;
                    end
                    RDW_READ_FIRST: begin
                        dat_o  <= rd_word;
                        rvalid <= 1'b1;
                    end
                    default: begin
                        rvalid <= 1'b0;
                    end
                endcase
            end
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: three 32x64 instances (one per read-during-write mode)
// share stimulus and are checked against a word-level reference model; a
// 256x32 instance covers the wider-address parameter set.
module tb_ram_sp_clr;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        sel;
    logic        we;
    logic [7:0]  be;
    logic [4:0]  adr;
    logic [63:0] dat_i;
    logic [63:0] dat_o_m [3];
    logic        rvalid_m [3];
    logic        busy_m [3];

    logic        w_sel;
    logic        w_we;
    logic [3:0]  w_be;
    logic [7:0]  w_adr;
    logic [31:0] w_dat_i;
    logic [31:0] w_dat_o;
    logic        w_rvalid;
    logic        w_busy;

    int passed;
    int total;

    // reference model state
    logic [63:0] mdl_mem [32];
    int          busy_left;
    logic [63:0] exp_dat [3];
    logic        exp_rv [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_sp_clr #(.AW(5), .DW(64), .RDW_MODE(g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .sel   (sel),
            .we    (we),
            .be    (be),
            .adr   (adr),
            .dat_i (dat_i),
            .dat_o (dat_o_m[g]),
            .rvalid(rvalid_m[g]),
            .busy  (busy_m[g])
        );
    end

    ram_sp_clr #(.AW(8), .DW(32), .RDW_MODE(0)) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .sel   (w_sel),
        .we    (w_we),
        .be    (w_be),
        .adr   (w_adr),
        .dat_i (w_dat_i),
        .dat_o (w_dat_o),
        .rvalid(w_rvalid),
        .busy  (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [63:0] old_w;
        logic [63:0] new_w;
        if (!rst_n) begin
            busy_left = 32;
            for (int a = 0; a < 32; a++) mdl_mem[a] = 64'd0;
            for (int m = 0; m < 3; m++) begin
                exp_dat[m] = 64'd0;
                exp_rv[m]  = 1'b0;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            for (int m = 0; m < 3; m++) exp_rv[m] = 1'b0;
        end else if (clr) begin
            busy_left = 32;
            for (int a = 0; a < 32; a++) mdl_mem[a] = 64'd0;
            for (int m = 0; m < 3; m++) exp_rv[m] = 1'b0;
        end else if (sel) begin
            old_w = mdl_mem[adr];
            if (we) begin
                new_w = old_w;
                for (int b = 0; b < 8; b++)
                    if (be[b]) new_w[8*b +: 8] = dat_i[8*b +: 8];
                mdl_mem[adr] = new_w;
                exp_rv[0]  = 1'b0;
                exp_dat[1] = new_w;
                exp_rv[1]  = 1'b1;
                exp_dat[2] = old_w;
                exp_rv[2]  = 1'b1;
            end else begin
                for (int m = 0; m < 3; m++) begin
                    exp_dat[m] = old_w;
                    exp_rv[m]  = 1'b1;
                end
            end
        end else begin
            for (int m = 0; m < 3; m++) exp_rv[m] = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d_busy", m), 64'(busy_m[m]), 64'(busy_left > 0));
            chk($sformatf("m%0d_rvalid", m), 64'(rvalid_m[m]), 64'(exp_rv[m]));
            chk($sformatf("m%0d_dat_o", m), dat_o_m[m], exp_dat[m]);
        end
    endtask

    task automatic acc(input logic s, input logic w, input logic [7:0] b,
                       input logic [4:0] a, input logic [63:0] d, input logic c);
        sel = s; we = w; be = b; adr = a; dat_i = d; clr = c;
        cyc();
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 8'h00, 5'd0, 64'd0, 1'b0);
    endtask

    task automatic count_busy(input string tag, input int expv);
        int n;
        n = 0;
        while (busy_m[0] && n < 100) begin
            n++;
            idle();
        end
        chk(tag, 64'(n), 64'(expv));
    endtask

    initial begin
        int n;
        passed = 0;
        total  = 0;
        busy_left = 32;
        for (int m = 0; m < 3; m++) begin
            exp_dat[m] = 64'd0;
            exp_rv[m]  = 1'b0;
        end
        w_sel = 1'b0; w_we = 1'b0; w_be = 4'h0; w_adr = 8'd0; w_dat_i = 32'd0;

        // reset for three cycles, then the clear must take 32 cycles
        rst_n = 1'b0;
        repeat (3) idle();
        rst_n = 1'b1;
        count_busy("reset_clear_len", 32);

        acc(1'b1, 1'b0, 8'h00, 5'd0, 64'd0, 1'b0);
        chk("rd0_zero", dat_o_m[0], 64'd0);
        acc(1'b1, 1'b0, 8'h00, 5'd17, 64'd0, 1'b0);
        chk("rd17_zero", dat_o_m[0], 64'd0);
        acc(1'b1, 1'b0, 8'h00, 5'd31, 64'd0, 1'b0);
        chk("rd31_zero", dat_o_m[1], 64'd0);

        // byte-enable merge
        acc(1'b1, 1'b1, 8'hFF, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        acc(1'b1, 1'b1, 8'h0F, 5'd5, 64'h1122_3344_5566_7788, 1'b0);
        acc(1'b1, 1'b0, 8'h00, 5'd5, 64'd0, 1'b0);
        chk("be_merge", dat_o_m[0], 64'hFFFF_FFFF_5566_7788);
        chk("be_rvalid", 64'(rvalid_m[0]), 64'd1);
        idle();
        chk("be_rvalid_drop", 64'(rvalid_m[0]), 64'd0);

        // read-during-write per mode
        acc(1'b1, 1'b1, 8'hFF, 5'd3, 64'hA, 1'b0);
        acc(1'b1, 1'b1, 8'hFF, 5'd3, 64'hB, 1'b0);
        chk("rdw_nc_dat", dat_o_m[0], 64'hFFFF_FFFF_5566_7788);
        chk("rdw_nc_rvalid", 64'(rvalid_m[0]), 64'd0);
        chk("rdw_wf_dat", dat_o_m[1], 64'hB);
        chk("rdw_rf_dat", dat_o_m[2], 64'hA);
        acc(1'b1, 1'b0, 8'h00, 5'd3, 64'd0, 1'b0);
        for (int m = 0; m < 3; m++) chk($sformatf("rdw_after_m%0d", m), dat_o_m[m], 64'hB);

        // clr while idle, with a same-cycle write that must be dropped
        for (int a = 0; a < 32; a++) acc(1'b1, 1'b1, 8'hFF, 5'(a), 64'h5555_5555_5555_5555, 1'b0);
        acc(1'b1, 1'b1, 8'hFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        count_busy("clr_len", 32);
        for (int a = 0; a < 32; a++) begin
            acc(1'b1, 1'b0, 8'h00, 5'(a), 64'd0, 1'b0);
            chk($sformatf("clr_rd%0d", a), dat_o_m[2], 64'd0);
        end

        // accesses during clear are ignored
        acc(1'b1, 1'b1, 8'hFF, 5'd9, 64'h9999_9999_9999_9999, 1'b0);
        acc(1'b0, 1'b0, 8'h00, 5'd0, 64'd0, 1'b1);
        acc(1'b1, 1'b1, 8'hFF, 5'd9, 64'h1234_5678_9ABC_DEF0, 1'b0);
        chk("busy_wr_rvalid", 64'(rvalid_m[1]), 64'd0);
        count_busy("busy_wr_clear_len", 31);
        acc(1'b1, 1'b0, 8'h00, 5'd9, 64'd0, 1'b0);
        chk("busy_wr_rd9", dat_o_m[0], 64'd0);

        // reset in the middle of a clear restarts it from address 0
        acc(1'b0, 1'b0, 8'h00, 5'd0, 64'd0, 1'b1);
        repeat (10) idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        count_busy("reset_mid_clear_len", 32);

        // randomized traffic with occasional clr and reset
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            acc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                5'($urandom), {$urandom, $urandom}, $urandom_range(0, 99) == 0);
        end
        rst_n = 1'b1;

        // wider parameter set: 256-word clear and 4-bit byte enables
        rst_n = 1'b0;
        repeat (2) idle();
        rst_n = 1'b1;
        n = 0;
        while (w_busy && n < 400) begin
            n++;
            idle();
        end
        chk("wide_clear_len", 64'(n), 64'd256);
        w_sel = 1'b1; w_we = 1'b1; w_be = 4'hF; w_adr = 8'd200; w_dat_i = 32'hAABB_CCDD;
        idle();
        w_be = 4'h5; w_dat_i = 32'h1122_3344;
        idle();
        w_we = 1'b0;
        idle();
        chk("wide_be_merge", 64'(w_dat_o), 64'hAA22_CC44);
        chk("wide_rvalid", 64'(w_rvalid), 64'd1);
        w_adr = 8'd255;
        idle();
        chk("wide_rd255_zero", 64'(w_dat_o), 64'd0);
        w_sel = 1'b0;
        idle();
        chk("wide_rvalid_drop", 64'(w_rvalid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
